// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the I/D-port SRAM-like arbiter: port IDs, grant FSM states, size codes.
`timescale 1ns/1ps
package sram_like_arbiter_pkg;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like channel: request fields from the master, handshake and read data from the slave.
`timescale 1ns/1ps
interface sram_like_arbiter_if #(parameter int AW = 32);
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [AW-1:0] wdata;
    logic          addr_ok;
    logic          data_ok;
    logic [AW-1:0] rdata;

    modport master (output req, wr, size, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, size, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter_id_fifo.sv
// In-order FIFO of 1-bit port IDs for accepted-but-unanswered transactions.
`timescale 1ns/1ps
module sram_like_arbiter_id_fifo #(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          push_id,
    input  logic          pop,
    output logic          head_id,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? bump(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? bump(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like slave between the instruction and data ports; responses are steered
// back in order using a FIFO of issuing-port IDs.
`timescale 1ns/1ps
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int AW          = 32
) (
    input  logic                clk,
    input  logic                reset,
    sram_like_arbiter_if.slave  i_bus,
    sram_like_arbiter_if.slave  d_bus,
    sram_like_arbiter_if.master m_bus,
    output logic                err_unexp
);

    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [AW-1:0] ZERO_DATA = '0;

    state_e        state_q, state_d;
    logic          locked_id_q, locked_id_d;
    logic          last_grant_q, last_grant_d;
    logic          err_q, err_d;

    logic          grant_valid, grant_id;
    logic          push, pop;
    logic          fifo_head, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    sram_like_arbiter_id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (grant_id),
        .pop     (pop),
        .head_id (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Fullness uses the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = PORT_I;
        if (!reset) begin
            if (state_q == ST_LOCK) begin
                grant_valid = 1'b1;
                grant_id    = locked_id_q;
            end else if (!fifo_full) begin
                if (i_bus.req && d_bus.req) begin
                    grant_valid = 1'b1;
                    grant_id    = other_port(last_grant_q);
                end else if (i_bus.req) begin
                    grant_valid = 1'b1;
                    grant_id    = PORT_I;
                end else if (d_bus.req) begin
                    grant_valid = 1'b1;
                    grant_id    = PORT_D;
                end
            end
        end
    end

    assign push = grant_valid && m_bus.addr_ok;
    assign pop  = !reset && m_bus.data_ok && (fifo_count != '0);

    always_comb begin
        m_bus.req     = grant_valid;
        m_bus.wr      = (grant_id == PORT_D) ? d_bus.wr    : i_bus.wr;
        m_bus.size    = (grant_id == PORT_D) ? d_bus.size  : i_bus.size;
        m_bus.wstrb   = (grant_id == PORT_D) ? d_bus.wstrb : i_bus.wstrb;
        m_bus.addr    = (grant_id == PORT_D) ? d_bus.addr  : i_bus.addr;
        m_bus.wdata   = (grant_id == PORT_D) ? d_bus.wdata : i_bus.wdata;

        i_bus.addr_ok = push && (grant_id == PORT_I);
        d_bus.addr_ok = push && (grant_id == PORT_D);

        i_bus.data_ok = pop && (fifo_head == PORT_I);
        d_bus.data_ok = pop && (fifo_head == PORT_D);
        i_bus.rdata   = i_bus.data_ok ? m_bus.rdata : ZERO_DATA;
        d_bus.rdata   = d_bus.data_ok ? m_bus.rdata : ZERO_DATA;
    end

    always_comb begin
        state_d      = state_q;
        locked_id_d  = locked_id_q;
        last_grant_d = last_grant_q;
        err_d        = err_q | (m_bus.data_ok && fifo_empty);
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    if (m_bus.addr_ok) begin
                        last_grant_d = grant_id;
                    end else begin
                        locked_id_d = grant_id;
                        state_d     = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                // Stay locked until the slave takes the held request, even if req drops.
                if (m_bus.addr_ok) begin
                    last_grant_d = locked_id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            locked_id_q  <= PORT_I;
            last_grant_q <= PORT_I;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            locked_id_q  <= locked_id_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign err_unexp = err_q;

endmodule
